fetch_byte_assembler: RTL and testbench

//  Upstream neighbour of the Y86 fetch/decode path. Consumes a byte stream from instruction

---
 rtl/fetch_byte_assembler.sv | 164 ++++++++++++++++
 tb/tb_fetch_byte_assembler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_assembler.sv
// Y86-64 fetch byte assembler: builds 1/2/9/10-byte instructions from an in-order byte stream
// and presents one decoded instruction per out_valid/out_ready handshake.
module fetch_byte_assembler #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  input  logic            flush_valid,
  input  logic [PC_W-1:0] flush_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [PC_W-1:0] valC,
  output logic [PC_W-1:0] valP,
  output logic [PC_W-1:0] pc,
  output logic            halt,
  output logic            invalid_instr
);

  typedef enum logic [2:0] {StOp, StReg, StConst, StOut, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, valc_q, valc_d, valp_q, valp_d;
  logic [3:0]      icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [3:0]      len_q, len_d, op_len;
  logic            inv_q, inv_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            take;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd1;
    endcase
  endfunction

  function automatic logic ifun_legal(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7:                                return fn <= 4'd6;
      4'h6:                                      return fn <= 4'd3;
      4'hC, 4'hD, 4'hE, 4'hF:                    return 1'b0;
      default:                                   return fn == 4'd0;
    endcase
  endfunction

  // Gated by rst_n so no byte is taken while reset is held.
  assign byte_ready = rst_n && !flush_valid &&
                      (state_q == StOp || state_q == StReg || state_q == StConst);
  assign take       = byte_valid && byte_ready;
  assign op_len     = instr_len(byte_data[7:4]);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    len_d   = len_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    if (flush_valid && state_q != StHalt) begin
      state_d = StOp;
      pc_d    = flush_pc;
      icode_d = '0;
      ifun_d  = '0;
      ra_d    = 4'hF;
      rb_d    = 4'hF;
      valc_d  = '0;
      valp_d  = flush_pc;
      len_d   = '0;
      inv_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StOp: if (take) begin
          icode_d = byte_data[7:4];
          ifun_d  = byte_data[3:0];
          len_d   = op_len;
          valp_d  = pc_q + PC_W'(op_len);
          inv_d   = !ifun_legal(byte_data[7:4], byte_data[3:0]);
          cnt_d   = '0;
          if (op_len == 4'd1)      state_d = StOut;
          else if (op_len == 4'd9) state_d = StConst;
          else                     state_d = StReg;
        end
        StReg: if (take) begin
          ra_d    = byte_data[7:4];
          rb_d    = byte_data[3:0];
          cnt_d   = '0;
          state_d = (len_q == 4'd2) ? StOut : StConst;
        end
        StConst: if (take) begin
          valc_d[{cnt_q, 3'b000} +: 8] = byte_data;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StOut;
        end
        StOut: if (out_ready) begin
          pc_d = valp_q;
          if (icode_q == 4'h0 || inv_q) begin
            state_d = StHalt;
          end else begin
            state_d = StOp;
            ra_d    = 4'hF;
            rb_d    = 4'hF;
            valc_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOp;
      pc_q    <= RESET_PC;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      valp_q  <= RESET_PC;
      len_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      len_q   <= len_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = (state_q == StOut);
  assign icode         = icode_q;
  assign ifun          = ifun_q;
  assign rA            = ra_q;
  assign rB            = rb_q;
  assign valC          = valc_q;
  assign valP          = valp_q;
  assign pc            = pc_q;
  assign halt          = out_valid && (icode_q == 4'h0);
  assign invalid_instr = out_valid && inv_q;

endmodule

// File: tb/tb_fetch_byte_assembler.sv
// Bench for fetch_byte_assembler: directed scenarios with literal expectations plus a random
// byte stream checked every cycle against an instruction-level model.
module tb_fetch_byte_assembler;

  localparam int unsigned PC_W     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            byte_valid = 1'b0;
  logic [7:0]      byte_data = 8'h0;
  logic            byte_ready;
  logic            flush_valid = 1'b0;
  logic [PC_W-1:0] flush_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [3:0]      icode, ifun, ra, rb;
  logic [PC_W-1:0] valc, valp, dut_pc;
  logic            halt, invalid_instr;

  always #5 clk = ~clk;

  fetch_byte_assembler #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(ra), .rB(rb),
    .valC(valc), .valP(valp), .pc(dut_pc),
    .halt(halt), .invalid_instr(invalid_instr)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: bytes of the instruction being gathered, the completed instruction awaiting
  // handshake, its start address, and the sticky halted condition.
  logic [7:0]  mbuf[$];
  logic [7:0]  ib[10];
  int          mlen;
  logic [63:0] mpc;
  bit          mpend, mhalted, took;
  logic [7:0]  ops[$] = '{8'h10, 8'h20, 8'h23, 8'h26, 8'h30, 8'h40, 8'h50, 8'h60, 8'h63,
                          8'h70, 8'h74, 8'h76, 8'h80, 8'h90, 8'hA0, 8'hB0};

  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  function automatic bit ilegal(input logic [3:0] ic, input logic [3:0] fn);
    if (ic >= 4'hC) return 0;
    if (ic == 4'h2 || ic == 4'h7) return fn <= 6;
    if (ic == 4'h6) return fn <= 3;
    return fn == 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
  task automatic cycle();
    logic        exp_ready, exp_valid, fl, hasreg;
    logic [3:0]  e_ic, e_fn;
    logic [63:0] e_vc;
    @(negedge clk);
    fl        = flush_valid && !mhalted;
    exp_valid = mpend;
    exp_ready = !mhalted && !mpend && !flush_valid;
    took      = 1'b0;
    chk("byte_ready", byte_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("pc", dut_pc, mpc);
    if (exp_valid) begin
      e_ic   = ib[0][7:4];
      e_fn   = ib[0][3:0];
      hasreg = (mlen == 2 || mlen == 10);
      e_vc   = '0;
      if (mlen >= 9)
        for (int k = 0; k < 8; k++) e_vc = e_vc | (64'(ib[mlen-8+k]) << (8 * k));
      chk("icode", icode, e_ic);
      chk("ifun", ifun, e_fn);
      chk("rA", ra, hasreg ? ib[1][7:4] : 4'hF);
      chk("rB", rb, hasreg ? ib[1][3:0] : 4'hF);
      chk("valC", valc, e_vc);
      chk("valP", valp, mpc + 64'(mlen));
      chk("halt", halt, e_ic == 4'h0);
      chk("invalid_instr", invalid_instr, !ilegal(e_ic, e_fn));
    end
    @(posedge clk);
    if (fl) begin
      mbuf.delete();
      mpend = 0;
      mpc   = flush_pc;
    end else if (exp_valid && out_ready) begin
      mpc   = mpc + 64'(mlen);
      mpend = 0;
      if (ib[0][7:4] == 4'h0 || !ilegal(ib[0][7:4], ib[0][3:0])) mhalted = 1;
    end else if (exp_ready && byte_valid) begin
      took = 1'b1;
      mbuf.push_back(byte_data);
      if (mbuf.size() == ilen(mbuf[0][7:4])) begin
        mlen = mbuf.size();
        for (int i = 0; i < mlen; i++) ib[i] = mbuf[i];
        mbuf.delete();
        mpend = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    byte_valid  = 0;
    flush_valid = 0;
    out_ready   = 0;
    rst_n       = 0;
    mbuf.delete();
    mpend   = 0;
    mhalted = 0;
    mpc     = RESET_PC;
    #1;
    chk("rst byte_ready", byte_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst pc", dut_pc, RESET_PC);
    chk("rst icode", {icode, ifun}, 0);
    chk("rst rA/rB", {ra, rb}, 8'hFF);
    chk("rst valC", valc, 0);
    chk("rst valP", valp, RESET_PC);
    chk("rst halt/invalid", {halt, invalid_instr}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1;
    byte_data  = b;
    took       = 0;
    while (!took && n < 50) begin
      cycle();
      n++;
    end
    if (!took) begin
      vectors++;
      errors++;
      $display("FAIL send timeout: byte %h not accepted within 50 cycles", b);
    end
    byte_valid = 0;
  endtask

  task automatic handshake();
    out_ready = 1;
    cycle();
    out_ready = 0;
  endtask

  initial begin
    logic [7:0] irm[10];
    irm = '{8'h30, 8'hF0, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    #2;
    do_reset();

    // irmovq, output exactly one cycle after the last byte
    for (int i = 0; i < 10; i++) send(irm[i]);
    chk("t1 out_valid", out_valid, 1);
    chk("t1 icode/ifun", {icode, ifun}, 8'h30);
    chk("t1 rA/rB", {ra, rb}, 8'hF0);
    chk("t1 valC", valc, 64'h0102030405060708);
    chk("t1 valP", valp, 64'd10);
    handshake();

    // nop, addq, ret back-to-back
    do_reset();
    out_ready = 1;
    send(8'h10);
    chk("t2 nop pc/valP", {dut_pc[7:0], valp[7:0]}, 16'h0001);
    send(8'h60);
    send(8'h23);
    chk("t2 addq pc/valP", {dut_pc[7:0], valp[7:0]}, 16'h0103);
    chk("t2 addq rA/rB", {ra, rb}, 8'h23);
    send(8'h90);
    chk("t2 ret pc/valP/rA", {dut_pc[7:0], valp[7:0], ra}, 20'h0304F);

    // output stalled by out_ready low
    out_ready  = 0;
    byte_valid = 1;
    byte_data  = 8'h10;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3 stall byte_ready", byte_ready, 0);
      chk("t3 stall icode", icode, 4'h9);
    end
    out_ready = 1;
    send(8'h10);
    chk("t3 next pc", dut_pc, 64'd4);
    cycle();
    out_ready = 0;

    // jXX abandoned by a flush mid-constant
    send(8'h70);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    flush_valid = 1;
    flush_pc    = 64'h40;
    byte_valid  = 1;
    byte_data   = 8'h04;
    cycle();
    chk("t4 flush out_valid", out_valid, 0);
    chk("t4 flush pc", dut_pc, 64'h40);
    flush_valid = 0;
    byte_valid  = 0;
    send(8'h10);
    chk("t4 post pc/valP", {dut_pc[7:0], valp[7:0]}, 16'h4041);
    handshake();

    // halt is sticky, flush ignored, reset recovers
    send(8'h00);
    chk("t5 halt", halt, 1);
    chk("t5 valP", valp, 64'h42);
    handshake();
    byte_valid = 1;
    flush_pc   = 64'h80;
    for (int i = 0; i < 20; i++) begin
      flush_valid = (i % 4 == 0);
      cycle();
      chk("t5 halted byte_ready", byte_ready, 0);
    end
    flush_valid = 0;
    do_reset();

    // illegal ifun and illegal icode
    send(8'h27);
    send(8'h00);
    chk("t6 cmov invalid/valP", {invalid_instr, valp[7:0]}, 9'h102);
    handshake();
    chk("t6 halted byte_ready", byte_ready, 0);
    do_reset();
    send(8'hC0);
    chk("t6 C0 invalid/halt/valP", {invalid_instr, halt, valp[7:0]}, 10'h201);
    handshake();
    do_reset();

    // valP wraps at the top of the address space
    flush_valid = 1;
    flush_pc    = '1;
    cycle();
    flush_valid = 0;
    send(8'h60);
    send(8'h01);
    chk("wrap valP", valp, 64'd1);
    handshake();

    // random stream
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ((mhalted && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) do_reset();
      byte_valid = ($urandom_range(0, 3) != 0);
      if (mbuf.size() == 0 && $urandom_range(0, 39) != 0)
        byte_data = ops[$urandom_range(0, ops.size() - 1)];
      else
        byte_data = 8'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush_valid = ($urandom_range(0, 29) == 0);
      flush_pc    = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
